// File: rtl/rs_alu_station_if.sv
// -----------------------------------------------------------------------------
// rs_alu_station_if
// Bundles the dispatch, CDB, flush and issue signals of the ALU reservation
// station into one interface.
//   master : the side that dispatches, broadcasts, flushes and accepts issue
//            (instruction decode / ROB / execute, or a testbench)
//   slave  : the reservation station itself
// Signal groups:
//   disp_*    dispatch request and operand/tag payload from stage_id
//   cdb_*     common data bus broadcast (wakeup)
//   rs_clear  flush of every entry (ROB clear on mispredict)
//   issue_*   selected instruction towards the ALU, valid/ready handshake
//   rs_full, free_count  occupancy status, derived from registered state
// -----------------------------------------------------------------------------
interface rs_alu_station_if #(
    parameter int RS_DEPTH  = 4,
    parameter int TAG_BITS  = 5,
    parameter int FUNC_BITS = 5
);
    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    // dispatch
    logic                 disp_valid;
    logic                 disp_opa_ready;
    logic [31:0]          disp_opa_value;
    logic [TAG_BITS-1:0]  disp_opa_tag;
    logic                 disp_opb_ready;
    logic [31:0]          disp_opb_value;
    logic [TAG_BITS-1:0]  disp_opb_tag;
    logic [TAG_BITS-1:0]  disp_dest_tag;
    logic [FUNC_BITS-1:0] disp_func;

    // wakeup broadcast
    logic                 cdb_valid;
    logic [TAG_BITS-1:0]  cdb_tag;
    logic [31:0]          cdb_value;

    // flush
    logic                 rs_clear;

    // issue
    logic                 issue_ready;
    logic                 issue_valid;
    logic [31:0]          issue_opa;
    logic [31:0]          issue_opb;
    logic [TAG_BITS-1:0]  issue_dest_tag;
    logic [FUNC_BITS-1:0] issue_func;

    // status
    logic                 rs_full;
    logic [CNT_W-1:0]     free_count;

    modport master (
        output disp_valid, disp_opa_ready, disp_opa_value, disp_opa_tag,
               disp_opb_ready, disp_opb_value, disp_opb_tag,
               disp_dest_tag, disp_func,
               cdb_valid, cdb_tag, cdb_value,
               rs_clear, issue_ready,
        input  issue_valid, issue_opa, issue_opb, issue_dest_tag, issue_func,
               rs_full, free_count
    );

    modport slave (
        input  disp_valid, disp_opa_ready, disp_opa_value, disp_opa_tag,
               disp_opb_ready, disp_opb_value, disp_opb_tag,
               disp_dest_tag, disp_func,
               cdb_valid, cdb_tag, cdb_value,
               rs_clear, issue_ready,
        output issue_valid, issue_opa, issue_opb, issue_dest_tag, issue_func,
               rs_full, free_count
    );
endinterface

// File: rtl/rs_alu_station.sv
// -----------------------------------------------------------------------------
// rs_alu_station
// Reservation station for renamed ALU instructions. Holds up to RS_DEPTH
// entries, captures missing operands from the CDB, and issues the oldest
// fully-ready entry each cycle under a valid/ready handshake.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    rs_alu_station_if.slave (dispatch, CDB, clear, issue, status)
// -----------------------------------------------------------------------------
module rs_alu_station #(
    parameter int RS_DEPTH  = 4,
    parameter int TAG_BITS  = 5,
    parameter int FUNC_BITS = 5
) (
    input  logic              clock,
    input  logic              reset,
    rs_alu_station_if.slave   bus
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_DEPTH - 1);

    // ---------------------------------------------------------------------
    // Entry storage
    // ---------------------------------------------------------------------
    logic [RS_DEPTH-1:0]  busy_q, busy_d;
    logic [RS_DEPTH-1:0]  opa_rdy_q, opa_rdy_d;
    logic [RS_DEPTH-1:0]  opb_rdy_q, opb_rdy_d;
    logic [31:0]          opa_val_q  [RS_DEPTH];
    logic [31:0]          opa_val_d  [RS_DEPTH];
    logic [31:0]          opb_val_q  [RS_DEPTH];
    logic [31:0]          opb_val_d  [RS_DEPTH];
    logic [TAG_BITS-1:0]  opa_tag_q  [RS_DEPTH];
    logic [TAG_BITS-1:0]  opa_tag_d  [RS_DEPTH];
    logic [TAG_BITS-1:0]  opb_tag_q  [RS_DEPTH];
    logic [TAG_BITS-1:0]  opb_tag_d  [RS_DEPTH];
    logic [TAG_BITS-1:0]  dest_tag_q [RS_DEPTH];
    logic [TAG_BITS-1:0]  dest_tag_d [RS_DEPTH];
    logic [FUNC_BITS-1:0] func_q     [RS_DEPTH];
    logic [FUNC_BITS-1:0] func_d     [RS_DEPTH];
    logic [IDX_W-1:0]     age_q      [RS_DEPTH];
    logic [IDX_W-1:0]     age_d      [RS_DEPTH];

    // ---------------------------------------------------------------------
    // Per-entry match / readiness vectors
    // ---------------------------------------------------------------------
    logic [RS_DEPTH-1:0] opa_hit;
    logic [RS_DEPTH-1:0] opb_hit;
    logic [RS_DEPTH-1:0] entry_ready;

    generate
        for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_match
            assign opa_hit[gi]     = bus.cdb_valid && busy_q[gi] && !opa_rdy_q[gi]
                                     && (opa_tag_q[gi] == bus.cdb_tag);
            assign opb_hit[gi]     = bus.cdb_valid && busy_q[gi] && !opb_rdy_q[gi]
                                     && (opb_tag_q[gi] == bus.cdb_tag);
            // Readiness comes from registered flags only, so a CDB hit this
            // cycle cannot make the entry issue until the next cycle.
            assign entry_ready[gi] = busy_q[gi] && opa_rdy_q[gi] && opb_rdy_q[gi];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Issue selection: highest age wins, strict compare keeps the lowest
    // index on ties.
    // ---------------------------------------------------------------------
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_age;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (entry_ready[i] && (!sel_found || (age_q[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Free-slot search and occupancy, both from registered busy bits
    // ---------------------------------------------------------------------
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] free_cnt;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        free_cnt   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!busy_q[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end
        end
    end

    logic full;
    logic disp_fire;
    logic issue_fire;

    assign full       = (free_cnt == '0);
    assign disp_fire  = bus.disp_valid && !full;
    assign issue_fire = sel_found && bus.issue_ready;

    // Dispatch operands with same-cycle CDB bypass
    logic        disp_a_byp, disp_b_byp;
    logic        disp_a_rdy, disp_b_rdy;
    logic [31:0] disp_a_val, disp_b_val;

    assign disp_a_byp = bus.cdb_valid && !bus.disp_opa_ready && (bus.disp_opa_tag == bus.cdb_tag);
    assign disp_b_byp = bus.cdb_valid && !bus.disp_opb_ready && (bus.disp_opb_tag == bus.cdb_tag);
    assign disp_a_rdy = bus.disp_opa_ready || disp_a_byp;
    assign disp_b_rdy = bus.disp_opb_ready || disp_b_byp;
    assign disp_a_val = disp_a_byp ? bus.cdb_value :
                        (bus.disp_opa_ready ? bus.disp_opa_value : 32'd0);
    assign disp_b_val = disp_b_byp ? bus.cdb_value :
                        (bus.disp_opb_ready ? bus.disp_opb_value : 32'd0);

    // ---------------------------------------------------------------------
    // Next-state for every entry
    // ---------------------------------------------------------------------
    always_comb begin
        busy_d    = busy_q;
        opa_rdy_d = opa_rdy_q;
        opb_rdy_d = opb_rdy_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            opa_val_d[i]  = opa_val_q[i];
            opb_val_d[i]  = opb_val_q[i];
            opa_tag_d[i]  = opa_tag_q[i];
            opb_tag_d[i]  = opb_tag_q[i];
            dest_tag_d[i] = dest_tag_q[i];
            func_d[i]     = func_q[i];
            age_d[i]      = age_q[i];

            if (bus.rs_clear || (issue_fire && (sel_idx == IDX_W'(i)))) begin
                // Flush beats everything; an issued entry simply empties.
                busy_d[i]     = 1'b0;
                opa_rdy_d[i]  = 1'b0;
                opb_rdy_d[i]  = 1'b0;
                opa_val_d[i]  = '0;
                opb_val_d[i]  = '0;
                opa_tag_d[i]  = '0;
                opb_tag_d[i]  = '0;
                dest_tag_d[i] = '0;
                func_d[i]     = '0;
                age_d[i]      = '0;
            end else if (busy_q[i]) begin
                if (opa_hit[i]) begin
                    opa_rdy_d[i] = 1'b1;
                    opa_val_d[i] = bus.cdb_value;
                end
                if (opb_hit[i]) begin
                    opb_rdy_d[i] = 1'b1;
                    opb_val_d[i] = bus.cdb_value;
                end
                if (disp_fire && (age_q[i] != AGE_MAX))
                    age_d[i] = age_q[i] + IDX_W'(1);
            end else if (disp_fire && (free_idx == IDX_W'(i))) begin
                // free_idx only ever points at a non-busy entry, so the slot
                // being issued this cycle is never reused until next cycle.
                busy_d[i]     = 1'b1;
                opa_rdy_d[i]  = disp_a_rdy;
                opb_rdy_d[i]  = disp_b_rdy;
                opa_val_d[i]  = disp_a_val;
                opb_val_d[i]  = disp_b_val;
                opa_tag_d[i]  = bus.disp_opa_tag;
                opb_tag_d[i]  = bus.disp_opb_tag;
                dest_tag_d[i] = bus.disp_dest_tag;
                func_d[i]     = bus.disp_func;
                age_d[i]      = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q    <= '0;
            opa_rdy_q <= '0;
            opb_rdy_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                opa_val_q[i]  <= '0;
                opb_val_q[i]  <= '0;
                opa_tag_q[i]  <= '0;
                opb_tag_q[i]  <= '0;
                dest_tag_q[i] <= '0;
                func_q[i]     <= '0;
                age_q[i]      <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            opa_rdy_q <= opa_rdy_d;
            opb_rdy_q <= opb_rdy_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                opa_val_q[i]  <= opa_val_d[i];
                opb_val_q[i]  <= opb_val_d[i];
                opa_tag_q[i]  <= opa_tag_d[i];
                opb_tag_q[i]  <= opb_tag_d[i];
                dest_tag_q[i] <= dest_tag_d[i];
                func_q[i]     <= func_d[i];
                age_q[i]      <= age_d[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.rs_full        = full;
    assign bus.free_count     = free_cnt;
    assign bus.issue_valid    = sel_found;
    assign bus.issue_opa      = sel_found ? opa_val_q[sel_idx]  : '0;
    assign bus.issue_opb      = sel_found ? opb_val_q[sel_idx]  : '0;
    assign bus.issue_dest_tag = sel_found ? dest_tag_q[sel_idx] : '0;
    assign bus.issue_func     = sel_found ? func_q[sel_idx]     : '0;

endmodule

// File: tb/tb_rs_alu_station.sv
// -----------------------------------------------------------------------------
// tb_rs_alu_station
// Directed bench for rs_alu_station. Expected issue transactions are queued
// by the stimulus once the instruction becomes issuable; a negedge monitor
// pops and compares every accepted issue. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_rs_alu_station;
    localparam int RS_DEPTH  = 4;
    localparam int TAG_BITS  = 5;
    localparam int FUNC_BITS = 5;

    typedef struct {
        logic [31:0]          opa;
        logic [31:0]          opb;
        logic [TAG_BITS-1:0]  dest;
        logic [FUNC_BITS-1:0] func;
    } exp_t;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    rs_alu_station_if #(.RS_DEPTH(RS_DEPTH), .TAG_BITS(TAG_BITS), .FUNC_BITS(FUNC_BITS)) bus ();

    rs_alu_station #(.RS_DEPTH(RS_DEPTH), .TAG_BITS(TAG_BITS), .FUNC_BITS(FUNC_BITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s ok value=%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid     = 1'b0;
        bus.disp_opa_ready = 1'b0;
        bus.disp_opa_value = '0;
        bus.disp_opa_tag   = '0;
        bus.disp_opb_ready = 1'b0;
        bus.disp_opb_value = '0;
        bus.disp_opb_tag   = '0;
        bus.disp_dest_tag  = '0;
        bus.disp_func      = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_value      = '0;
        bus.rs_clear       = 1'b0;
    endtask

    // Present one dispatch for a single edge, then withdraw it.
    task automatic dispatch(input logic ar, input logic [31:0] av, input logic [4:0] at,
                            input logic br, input logic [31:0] bv, input logic [4:0] bt,
                            input logic [4:0] dest, input logic [4:0] func);
        bus.disp_valid     = 1'b1;
        bus.disp_opa_ready = ar;
        bus.disp_opa_value = av;
        bus.disp_opa_tag   = at;
        bus.disp_opb_ready = br;
        bus.disp_opb_value = bv;
        bus.disp_opb_tag   = bt;
        bus.disp_dest_tag  = dest;
        bus.disp_func      = func;
        step();
        bus.disp_valid     = 1'b0;
    endtask

    task automatic broadcast(input logic [4:0] tag, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = val;
        step();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] d, input logic [4:0] f);
        exp_t e;
        e.opa  = a;
        e.opb  = b;
        e.dest = d;
        e.func = f;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && bus.issue_valid && bus.issue_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL issue_unexpected actual dest=%0d opa=%0h required no issue",
                             bus.issue_dest_tag, bus.issue_opa);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.issue_opa !== e.opa || bus.issue_opb !== e.opb ||
                        bus.issue_dest_tag !== e.dest || bus.issue_func !== e.func) begin
                        failures++;
                        $display("FAIL issue actual opa=%0h opb=%0h dest=%0d func=%0d required opa=%0h opb=%0h dest=%0d func=%0d",
                                 bus.issue_opa, bus.issue_opb, bus.issue_dest_tag, bus.issue_func,
                                 e.opa, e.opb, e.dest, e.func);
                    end else begin
                        $display("issue ok opa=%0h opb=%0h dest=%0d func=%0d",
                                 e.opa, e.opb, e.dest, e.func);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        idle_inputs();
        bus.issue_ready = 1'b0;
        repeat (2) step();
        chk("reset_free_count", 32'(bus.free_count), 32'd4);
        chk("reset_rs_full", 32'(bus.rs_full), 32'd0);
        chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("reset_issue_opa", bus.issue_opa, 32'd0);
        reset = 1'b1;
        step();

        // 1: ready dispatch issues next cycle, then frees
        bus.issue_ready = 1'b1;
        dispatch(1'b1, 32'd10, 5'd0, 1'b1, 32'd20, 5'd0, 5'd3, 5'd0);
        expect_issue(32'd10, 32'd20, 5'd3, 5'd0);
        chk("t1_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_free_count_busy", 32'(bus.free_count), 32'd3);
        step();
        chk("t1_free_count_after", 32'(bus.free_count), 32'd4);

        // 2: wakeup through CDB
        dispatch(1'b0, 32'd0, 5'd7, 1'b1, 32'd5, 5'd0, 5'd4, 5'd2);
        chk("t2_wait_issue_valid", 32'(bus.issue_valid), 32'd0);
        broadcast(5'd7, 32'h55);
        expect_issue(32'h55, 32'd5, 5'd4, 5'd2);
        chk("t2_woken_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t2_woken_opa", bus.issue_opa, 32'h55);
        step();
        chk("t2_free_count_after", 32'(bus.free_count), 32'd4);

        // 3: same-cycle bypass on dispatch
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 5'd9;
        bus.cdb_value = 32'h99;
        dispatch(1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0, 5'd5, 5'd3);
        bus.cdb_valid = 1'b0;
        expect_issue(32'h99, 32'd1, 5'd5, 5'd3);
        chk("t3_bypass_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t3_bypass_opa", bus.issue_opa, 32'h99);
        step();

        // 4: fill, drop when full, oldest-first drain
        bus.issue_ready = 1'b0;
        for (int d = 1; d <= 4; d++)
            dispatch(1'b1, 32'(d * 16), 5'd0, 1'b1, 32'(d), 5'd0, 5'(d), 5'(d));
        chk("t4_rs_full", 32'(bus.rs_full), 32'd1);
        chk("t4_free_count", 32'(bus.free_count), 32'd0);
        dispatch(1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF, 5'd0, 5'd12, 5'd1);
        chk("t4_full_after_drop", 32'(bus.free_count), 32'd0);
        chk("t4_hold_dest", 32'(bus.issue_dest_tag), 32'd1);
        for (int d = 1; d <= 4; d++)
            expect_issue(32'(d * 16), 32'(d), 5'(d), 5'(d));
        bus.issue_ready = 1'b1;
        repeat (6) step();
        chk("t4_free_count_drained", 32'(bus.free_count), 32'd4);

        // simultaneous issue + dispatch keeps free_count
        bus.issue_ready = 1'b0;
        dispatch(1'b1, 32'd6, 5'd0, 1'b1, 32'd60, 5'd0, 5'd6, 5'd4);
        expect_issue(32'd6, 32'd60, 5'd6, 5'd4);
        bus.issue_ready = 1'b1;
        dispatch(1'b1, 32'd7, 5'd0, 1'b1, 32'd70, 5'd0, 5'd7, 5'd5);
        expect_issue(32'd7, 32'd70, 5'd7, 5'd5);
        chk("issue_disp_free_count", 32'(bus.free_count), 32'd3);
        step();
        chk("issue_disp_drained", 32'(bus.free_count), 32'd4);

        // 5: clear beats a concurrent dispatch; later wakeup finds nothing
        dispatch(1'b0, 32'd0, 5'd2, 1'b1, 32'd0, 5'd0, 5'd13, 5'd0);
        dispatch(1'b0, 32'd0, 5'd3, 1'b1, 32'd0, 5'd0, 5'd14, 5'd0);
        dispatch(1'b0, 32'd0, 5'd4, 1'b1, 32'd0, 5'd0, 5'd15, 5'd0);
        chk("t5_free_count_filled", 32'(bus.free_count), 32'd1);
        bus.rs_clear = 1'b1;
        dispatch(1'b1, 32'd1, 5'd0, 1'b1, 32'd2, 5'd0, 5'd20, 5'd0);
        bus.rs_clear = 1'b0;
        chk("t5_free_count_cleared", 32'(bus.free_count), 32'd4);
        broadcast(5'd2, 32'h22);
        chk("t5_issue_valid_after_cdb", 32'(bus.issue_valid), 32'd0);
        chk("t5_free_count_after_cdb", 32'(bus.free_count), 32'd4);

        // 6: asynchronous reset mid-cycle
        bus.issue_ready = 1'b0;
        dispatch(1'b1, 32'd8, 5'd0, 1'b1, 32'd80, 5'd0, 5'd8, 5'd0);
        dispatch(1'b1, 32'd9, 5'd0, 1'b1, 32'd90, 5'd0, 5'd9, 5'd0);
        chk("t6_free_count_busy", 32'(bus.free_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_free_count", 32'(bus.free_count), 32'd4);
        chk("t6_async_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("t6_async_issue_opa", bus.issue_opa, 32'd0);
        #1;
        reset = 1'b1;
        bus.issue_ready = 1'b1;
        repeat (3) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_alu_station.md
Name: rs_alu_station

Overview:
- Reservation station directly downstream of stage_id.
- Accepts one renamed ALU instruction per cycle: operand values or ROB tags, destination ROB tag and ALU function.
- Captures missing operands from the CDB broadcast.
- Issues one ready instruction per cycle to the ALU/execute stage under a valid/ready handshake.
- Flushed by the ROB clear on mispredict.

Parameters:
RS_DEPTH, 4, number of entries (power of two, 2..16)
TAG_BITS, 5, ROB tag width (matches ROB_TAG_BITS)
FUNC_BITS, 5, ALU function code width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
disp_valid  input  1  dispatch request from stage_id
disp_opa_ready  input  1  opA holds a value (1) or waits on disp_opa_tag (0)
disp_opa_value  input  32  opA value
disp_opa_tag  input  TAG_BITS  ROB tag producing opA
disp_opb_ready  input  1  as opA, for opB
disp_opb_value  input  32  opB value
disp_opb_tag  input  TAG_BITS  ROB tag producing opB
disp_dest_tag  input  TAG_BITS  ROB tag of this instruction
disp_func  input  FUNC_BITS  ALU function
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_BITS  broadcast tag
cdb_value  input  32  broadcast value
rs_clear  input  1  flush all entries (ROB clear)
issue_ready  input  1  execute stage accepts issue
rs_full  output  1  all entries busy
issue_valid  output  1  an entry is ready to issue
issue_opa  output  32  opA of issuing entry
issue_opb  output  32  opB of issuing entry
issue_dest_tag  output  TAG_BITS  dest tag of issuing entry
issue_func  output  FUNC_BITS  function of issuing entry
free_count  output  clog2(RS_DEPTH)+1  number of free entries

Behaviour:
- Entry state: busy, opa_rdy, opa_val, opa_tag, opb_rdy, opb_val, opb_tag, dest_tag, func, age (clog2(RS_DEPTH) bits).
- Reset (reset==0, async):
  - All entries cleared (busy=0), all fields zero.
  - Outputs: rs_full=0, issue_valid=0, issue_* =0, free_count=RS_DEPTH.
- Dispatch:
  - Accepted at a posedge when disp_valid=1 and rs_full=0.
  - Written into the lowest-index free entry; its age is set to 0.
  - When rs_full=1, dispatch is ignored; upstream must stall. This holds even if an issue frees an entry in the same cycle, because rs_full is computed from registered state.
- Wakeup:
  - On a posedge with cdb_valid=1, every busy entry with a not-ready operand whose tag equals cdb_tag sets that operand's rdy=1 and value=cdb_value.
  - Same-cycle bypass: a dispatching operand with rdy=0 and tag==cdb_tag is written with rdy=1 and value=cdb_value.
  - One operand slot of one entry may match on both opA and opB; both are captured.
- Ages:
  - Every busy entry that is not issued increments age, saturating at RS_DEPTH-1, on each accepted dispatch.
  - Issue is oldest-first: highest age wins; ties go to the lowest index.
- Issue (combinational from registered state):
  - issue_valid=1 iff some busy entry has opa_rdy && opb_rdy.
  - issue_* reflect the selected entry; zero when issue_valid=0.
  - Selected entry is freed at a posedge when issue_valid && issue_ready.
  - Latency: dispatched ready → issue_valid the next cycle. CDB wakeup at edge N → issuable from cycle N+1.
  - A CDB broadcast never makes an entry issue in the same cycle.
  - issue_* hold stable while issue_valid=1 and issue_ready=0, unless an older entry becomes ready; the selection may then change.
- Clear:
  - rs_clear=1 at a posedge empties all entries.
  - Clear has priority over dispatch, wakeup and issue in that cycle.
  - Outputs return to reset values the next cycle.
- free_count and rs_full are registered-state derived: rs_full = (free_count==0).
- Simultaneous issue + dispatch (not full) in one cycle:
  - Both occur; free_count unchanged.
  - The newly dispatched entry may reuse a freed index only from the next cycle; it never takes the entry being issued.
- Reset mid-operation discards all entries immediately (async).

Test Plan:
1. Reset, dispatch opA=10 (rdy), opB=20 (rdy), dest=3, func=0 → next cycle issue_valid=1, opa=10, opb=20, dest=3. With issue_ready=1, the entry frees and free_count returns to 4.
2. Dispatch opA waiting tag 7, opB=5 (rdy) → issue_valid=0. Then CDB tag7=0x55 → next cycle issue_valid=1, issue_opa=0x55.
3. Dispatch waiting tag 9 in the same cycle as CDB tag9=0x99 → captured via bypass; issue_valid=1 next cycle with opa=0x99.
4. Dispatch 4 ready entries with issue_ready=0 → rs_full=1, free_count=0. A 5th dispatch (dest=12) is dropped. Then with issue_ready=1, issue order of dests is 1,2,3,4.
5. Fill 3 entries waiting on tags 2/3/4, pulse rs_clear, then broadcast CDB tag 2 → issue_valid stays 0 and free_count=4.
6. Assert reset=0 asynchronously mid-cycle with 2 busy entries → free_count=4 and issue_valid=0 immediately, before the next clock edge.
